// File: rtl/wormhole_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : wormhole_arbiter_if
// Brief    : Flit input bundle and registered output link of the wormhole arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface wormhole_arbiter_if #(
    parameter int NUM_INPUTS = 5,
    parameter int WIDTH      = 73,
    parameter int IDX_W      = $clog2(NUM_INPUTS)
);
    logic [NUM_INPUTS-1:0][WIDTH-1:0] i_data;
    logic [NUM_INPUTS-1:0]            i_valid;
    logic [NUM_INPUTS-1:0]            i_last;
    logic [NUM_INPUTS-1:0]            o_ready;
    logic [WIDTH-1:0]                 o_data;
    logic                             o_last;
    logic                             o_valid;
    logic [IDX_W-1:0]                 o_src_idx;
    logic                             o_locked;
    logic                             i_ready;

    // Traffic source and sink around the arbiter.
    modport master (
        output i_data, i_valid, i_last, i_ready,
        input  o_ready, o_data, o_last, o_valid, o_src_idx, o_locked
    );

    // The arbiter itself.
    modport slave (
        input  i_data, i_valid, i_last, i_ready,
        output o_ready, o_data, o_last, o_valid, o_src_idx, o_locked
    );
endinterface
`default_nettype wire

// File: rtl/wormhole_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wormhole_arbiter
// Brief    : N:1 packet-locking flit arbiter (round-robin or fixed priority)
//            with one registered output stage.
// Revision : 1.0 - initial release
// ============================================================================
module wormhole_arbiter #(
    parameter int NUM_INPUTS = 5,
    parameter int WIDTH      = 73,
    parameter int RR_MODE    = 1,
    parameter int IDX_W      = $clog2(NUM_INPUTS)
) (
    input  wire logic         i_clk,
    input  wire logic         i_arst_n,
    wormhole_arbiter_if.slave bus
);
    localparam logic [0:0]       S_UNLOCKED = 1'b0;
    localparam logic [0:0]       S_LOCKED   = 1'b1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_INPUTS - 1);
    localparam logic [IDX_W:0]   C_NUM      = (IDX_W + 1)'(NUM_INPUTS);

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic                  w_locked;
    logic [IDX_W-1:0]      r_lock_idx;
    logic [IDX_W-1:0]      r_rr_ptr;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic [WIDTH-1:0]      r_out_data;
    logic [IDX_W-1:0]      r_out_src;

    logic                  w_space;
    logic                  w_found;
    logic                  w_has_sel;
    logic                  w_xfer;
    logic                  w_xfer_last;
    logic [IDX_W-1:0]      w_base;
    logic [IDX_W-1:0]      w_free_sel;
    logic [IDX_W-1:0]      w_sel;
    logic [IDX_W:0]        w_cand;
    logic [NUM_INPUTS-1:0] w_ready;

    assign w_space = !r_out_valid || bus.i_ready;

    // Circular search from the pointer; the pointer stays 0 in fixed-priority
    // mode, so the same search yields the lowest valid index there.
    always_comb begin
        w_base     = (RR_MODE != 0) ? r_rr_ptr : '0;
        w_found    = 1'b0;
        w_free_sel = '0;
        w_cand     = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            w_cand = {1'b0, w_base} + (IDX_W + 1)'(i);
            if (w_cand >= C_NUM) begin
                w_cand = w_cand - C_NUM;
            end
            if (!w_found && bus.i_valid[w_cand[IDX_W-1:0]]) begin
                w_found    = 1'b1;
                w_free_sel = w_cand[IDX_W-1:0];
            end
        end
    end

    assign w_sel     = w_locked ? r_lock_idx : w_free_sel;
    assign w_has_sel = w_locked || w_found;

    always_comb begin
        w_ready = '0;
        if (w_has_sel && w_space && i_arst_n) begin
            w_ready[w_sel] = 1'b1;
        end
    end

    assign w_xfer      = |(w_ready & bus.i_valid);
    assign w_xfer_last = bus.i_last[w_sel];

    // Lock state machine: state register
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state <= S_UNLOCKED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Lock state machine: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_UNLOCKED: if (w_xfer && !w_xfer_last) w_state_nxt = S_LOCKED;
            S_LOCKED:   if (w_xfer && w_xfer_last)  w_state_nxt = S_UNLOCKED;
            default:    w_state_nxt = S_UNLOCKED;
        endcase
    end

    // Lock state machine: outputs
    always_comb begin
        w_locked = (r_state == S_LOCKED);
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_lock_idx <= '0;
            r_rr_ptr   <= '0;
        end else begin
            if (w_xfer && !w_locked && !w_xfer_last) begin
                r_lock_idx <= w_sel;
            end
            // Pointer only advances at packet boundaries, with explicit wrap.
            if ((RR_MODE != 0) && w_xfer && w_xfer_last) begin
                r_rr_ptr <= (w_sel == C_LAST_IDX) ? '0 : w_sel + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_last  <= w_xfer_last;
            r_out_data  <= bus.i_data[w_sel];
            r_out_src   <= w_sel;
        end else if (bus.i_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.o_ready   = w_ready;
    assign bus.o_valid   = r_out_valid;
    assign bus.o_last    = r_out_last;
    assign bus.o_data    = r_out_data;
    assign bus.o_src_idx = r_out_src;
    assign bus.o_locked  = w_locked;

    a_ready_onehot: assert property (@(posedge i_clk) disable iff (!i_arst_n)
        $onehot0(w_ready));

    a_hold_stable: assert property (@(posedge i_clk) disable iff (!i_arst_n)
        (r_out_valid && !bus.i_ready) |=>
        ($stable(r_out_data) && $stable(r_out_last) && $stable(r_out_src)));
endmodule
`default_nettype wire

// File: tb/tb_wormhole_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wormhole_arbiter
// Brief    : Self-checking bench for wormhole_arbiter (RR and fixed priority).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wormhole_arbiter;
    localparam int N  = 5;
    localparam int W  = 73;
    localparam int IW = 3;

    typedef struct { logic [W-1:0] data; logic last; } flit_t;
    typedef struct { logic [IW-1:0] src; logic [W-1:0] data; logic last; } exp_t;
    typedef struct { logic [N-1:0] valid; logic [N-1:0] ready; } vec_t;

    logic clk = 1'b0;
    logic arst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    flit_t  mem [N][64];
    int     head [N];
    int     tail [N];
    int     sent_cnt [N];
    int     exp_cnt [N];
    exp_t   q_exp [$];
    logic [N-1:0] take;
    logic [N-1:0] hold;
    logic   rdy;
    vec_t   tbl [7];
    logic [W-1:0] bp_exp_data;

    wormhole_arbiter_if #(.NUM_INPUTS(N), .WIDTH(W)) rbus ();
    wormhole_arbiter_if #(.NUM_INPUTS(N), .WIDTH(W)) fbus ();

    wormhole_arbiter #(.NUM_INPUTS(N), .WIDTH(W), .RR_MODE(1)) u_rr (
        .i_clk(clk), .i_arst_n(arst_n), .bus(rbus)
    );
    wormhole_arbiter #(.NUM_INPUTS(N), .WIDTH(W), .RR_MODE(0)) u_fp (
        .i_clk(clk), .i_arst_n(arst_n), .bus(fbus)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk_data(input int src, input int idx);
        logic [W-1:0] d;
        d          = '0;
        d[W-1]     = 1'b1;
        d[40 +: 8] = 8'h5A;
        d[16 +: 8] = src[7:0];
        d[0 +: 16] = idx[15:0];
        return d;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send_pkt(input int src, input int n);
        for (int f = 0; f < n; f++) begin
            mem[src][tail[src]].data = mk_data(src, sent_cnt[src]);
            mem[src][tail[src]].last = (f == n - 1);
            tail[src]++;
            sent_cnt[src]++;
        end
    endtask

    task automatic exp_flit(input int src, input logic last);
        exp_t e;
        e.src  = IW'(src);
        e.data = mk_data(src, exp_cnt[src]);
        e.last = last;
        q_exp.push_back(e);
        exp_cnt[src]++;
    endtask

    task automatic exp_pkt(input int src, input int n);
        for (int f = 0; f < n; f++) begin
            exp_flit(src, f == n - 1);
        end
    endtask

    // One clock of the RR DUT: retire accepted flits, drive, then sample.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            if (take[k]) head[k]++;
        end
        for (int k = 0; k < N; k++) begin
            rbus.i_valid[k] = (head[k] != tail[k]) && !hold[k];
            rbus.i_data[k]  = (head[k] != tail[k]) ? mem[k][head[k]].data : '0;
            rbus.i_last[k]  = (head[k] != tail[k]) ? mem[k][head[k]].last : 1'b0;
        end
        rbus.i_ready = rdy;
        #1;
        take = rbus.i_valid & rbus.o_ready;
        if (rbus.o_valid && rbus.i_ready) begin
            if (q_exp.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_extra: got src %0d data %0h expected no flit", rbus.o_src_idx, rbus.o_data);
            end else begin
                e = q_exp.pop_front();
                check("sb_src", rbus.o_src_idx, e.src);
                check("sb_data", rbus.o_data, e.data);
                check("sb_last", rbus.o_last, e.last);
            end
        end
    endtask

    initial begin
        arst_n       = 1'b0;
        take         = '0;
        hold         = '0;
        rdy          = 1'b1;
        rbus.i_valid = '1;
        rbus.i_last  = '1;
        rbus.i_data  = '0;
        rbus.i_ready = 1'b1;
        fbus.i_valid = '1;
        fbus.i_last  = '1;
        fbus.i_data  = '0;
        fbus.i_ready = 1'b1;

        tbl[0] = '{5'b00000, 5'b00000};
        tbl[1] = '{5'b00001, 5'b00001};
        tbl[2] = '{5'b11000, 5'b01000};
        tbl[3] = '{5'b10100, 5'b00100};
        tbl[4] = '{5'b11111, 5'b00001};
        tbl[5] = '{5'b10000, 5'b10000};
        tbl[6] = '{5'b01010, 5'b00010};

        #12;
        check("rst_o_valid", rbus.o_valid, 0);
        check("rst_o_data", rbus.o_data, 0);
        check("rst_o_last", rbus.o_last, 0);
        check("rst_o_src", rbus.o_src_idx, 0);
        check("rst_o_locked", rbus.o_locked, 0);
        check("rst_o_ready_rr", rbus.o_ready, 0);
        check("rst_o_ready_fp", fbus.o_ready, 0);
        rbus.i_valid = '0;
        fbus.i_valid = '0;
        @(negedge clk);
        arst_n = 1'b1;

        // Fixed-priority selection table; valids removed before each edge
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            fbus.i_valid = tbl[i].valid;
            #1;
            check($sformatf("tbl%0d_ready", i), fbus.o_ready, tbl[i].ready);
            #1;
            fbus.i_valid = '0;
        end
        @(negedge clk);
        #1;
        check("tbl_no_xfer", fbus.o_valid, 0);

        // Single-flit round-robin fairness
        for (int r = 0; r < 2; r++) for (int k = 0; k < N; k++) send_pkt(k, 1);
        for (int r = 0; r < 2; r++) for (int k = 0; k < N; k++) exp_pkt(k, 1);
        for (int c = 0; c <= 10; c++) begin
            cycle();
            if (c >= 1) check($sformatf("rr_valid_c%0d", c), rbus.o_valid, 1);
        end

        // Packet locking against a competing input
        send_pkt(1, 4);
        for (int r = 0; r < 3; r++) send_pkt(2, 1);
        exp_pkt(1, 4);
        for (int r = 0; r < 3; r++) exp_pkt(2, 1);
        for (int c = 0; c <= 7; c++) begin
            cycle();
            check($sformatf("lock_locked_c%0d", c), rbus.o_locked, (c >= 1 && c <= 3));
            if (c <= 3) check($sformatf("lock_rdy2_c%0d", c), rbus.o_ready[2], 0);
            if (c == 4) check("lock_rdy2_after_tail", rbus.o_ready[2], 1);
            if (c >= 1) check($sformatf("lock_valid_c%0d", c), rbus.o_valid, 1);
        end

        // Mid-packet bubble on the locked input
        send_pkt(3, 3);
        send_pkt(0, 1);
        exp_pkt(3, 3);
        exp_pkt(0, 1);
        for (int c = 0; c <= 6; c++) begin
            hold[3] = (c == 1 || c == 2);
            cycle();
            if (c == 2 || c == 3) check($sformatf("bubble_valid_c%0d", c), rbus.o_valid, 0);
            if (c >= 1 && c <= 4) check($sformatf("bubble_rdy0_c%0d", c), rbus.o_ready[0], 0);
        end
        hold = '0;

        // Backpressure hold
        bp_exp_data = mk_data(2, sent_cnt[2]);
        send_pkt(2, 3);
        send_pkt(4, 1);
        exp_pkt(2, 3);
        exp_pkt(4, 1);
        for (int c = 0; c <= 11; c++) begin
            rdy = !(c >= 1 && c <= 5);
            cycle();
            if (c >= 1 && c <= 5) begin
                check($sformatf("bp_rdy_c%0d", c), rbus.o_ready, 0);
                check($sformatf("bp_valid_c%0d", c), rbus.o_valid, 1);
                check($sformatf("bp_data_c%0d", c), rbus.o_data, bp_exp_data);
                check($sformatf("bp_src_c%0d", c), rbus.o_src_idx, 2);
            end
        end
        rdy = 1'b1;
        check("sb_empty_1", q_exp.size(), 0);

        // Fixed priority starves input 3
        fbus.i_data    = '0;
        fbus.i_data[0] = mk_data(0, 100);
        fbus.i_data[3] = mk_data(3, 100);
        fbus.i_last    = '1;
        fbus.i_ready   = 1'b1;
        @(negedge clk);
        fbus.i_valid = 5'b01001;
        for (int c = 0; c <= 7; c++) begin
            #1;
            check($sformatf("fp_rdy_c%0d", c), fbus.o_ready, 5'b00001);
            if (c >= 1) begin
                check($sformatf("fp_valid_c%0d", c), fbus.o_valid, 1);
                check($sformatf("fp_src_c%0d", c), fbus.o_src_idx, 0);
                check($sformatf("fp_data_c%0d", c), fbus.o_data, mk_data(0, 100));
            end
            @(negedge clk);
        end
        fbus.i_valid = '0;

        // Async reset in the middle of a packet, with the pointer moved to 4
        send_pkt(3, 1);
        exp_pkt(3, 1);
        cycle();
        send_pkt(1, 3);
        exp_flit(1, 1'b0);
        cycle();
        cycle();
        check("arst_pre_locked", rbus.o_locked, 1);
        #1;
        arst_n = 1'b0;
        #1;
        check("arst_valid", rbus.o_valid, 0);
        check("arst_locked", rbus.o_locked, 0);
        check("arst_rdy", rbus.o_ready, 0);
        @(negedge clk);
        #1;
        check("arst_hold_rdy", rbus.o_ready, 0);
        check("arst_hold_valid", rbus.o_valid, 0);
        for (int k = 0; k < N; k++) begin
            head[k]    = 0;
            tail[k]    = 0;
            exp_cnt[k] = sent_cnt[k];
        end
        take         = '0;
        rbus.i_valid = '0;
        @(negedge clk);
        arst_n = 1'b1;
        send_pkt(4, 1);
        send_pkt(0, 1);
        exp_pkt(0, 1);
        exp_pkt(4, 1);
        cycle();
        check("post_rst_rdy", rbus.o_ready, 5'b00001);
        for (int c = 0; c < 3; c++) cycle();
        check("sb_empty_2", q_exp.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/wormhole_arbiter.md
Name: wormhole_arbiter

Overview:
- N:1 flit arbiter for the router output port, replacing the single-flit round-robin arbiter.
- Locks the grant to one input for a whole multi-flit packet (head to tail), so packets are never interleaved.
- Selectable round-robin or fixed-priority mode.
- One registered output stage that sustains full throughput and breaks the combinational ready path. Sits between the input FIFOs and the link or crossbar output.

Parameters:
- NUM_INPUTS, 5, number of input channels; must be >= 2.
- WIDTH, 73, flit width in bits.
- RR_MODE, 1, 1 = round-robin; 0 = fixed priority (lowest index wins).
- IDX_W, $clog2(NUM_INPUTS), derived width of the input index; not overridden.

Ports:
- i_clk  in  1  clock.
- i_arst_n  in  1  reset, asynchronous, active-low.
- i_data  in  [NUM_INPUTS][WIDTH]  flit per input.
- i_valid  in  NUM_INPUTS  flit valid per input.
- i_last  in  NUM_INPUTS  tail-flit marker per input; a single-flit packet has i_last=1 on its only flit.
- o_ready  out  NUM_INPUTS  accept per input; at most one bit set (one-hot or zero).
- o_data  out  WIDTH  registered output flit.
- o_last  out  1  registered tail marker.
- o_valid  out  1  registered output valid.
- o_src_idx  out  IDX_W  index of the input that supplied the flit currently in the output register.
- o_locked  out  1  an unfinished packet currently holds the grant.
- i_ready  in  1  downstream accept.

Behaviour:
- Reset values:
  - o_valid=0, o_data=0, o_last=0, o_src_idx=0.
  - Lock flag=0, lock index=0, RR pointer=0.
  - o_ready=0 while i_arst_n is low.
- Handshake:
  - An input flit transfers when i_valid[k] && o_ready[k].
  - An output flit transfers when o_valid && i_ready.
  - space = !o_valid || i_ready.
- Selection, unlocked:
  - RR_MODE=1: sel is the first k with i_valid[k]=1, searching from the pointer upward and wrapping at NUM_INPUTS-1 to 0.
  - RR_MODE=0: sel is the lowest k with i_valid[k]=1.
  - If no input is valid, there is no selection.
- Selection, locked: sel = lock index only. All other inputs see o_ready=0, even when valid. If the locked input deasserts valid, the output bubbles; the grant never switches mid-packet.
- o_ready[sel] = space. All other o_ready bits are 0.
- Output register:
  - On an input transfer, load o_data, o_last, o_src_idx from sel and set o_valid=1.
  - Else if i_ready, clear o_valid. o_data is held.
  - Latency: 1 cycle from input transfer to o_valid.
  - Throughput: 1 flit/cycle while i_ready=1.
  - When i_ready=0 and o_valid=1, the output register holds and all o_ready bits are 0 (no flit is lost).
- Lock state machine, two states:
  - UNLOCKED -> LOCKED on a transfer with i_last[sel]=0; lock index = sel.
  - LOCKED -> UNLOCKED on a transfer with i_last[lock index]=1.
  - A single-flit packet never enters LOCKED.
  - o_locked = LOCKED state, registered.
- RR pointer:
  - Updates only on a transfer of a tail flit: pointer = (sel == NUM_INPUTS-1) ? 0 : sel+1.
  - Wrap is explicit, so it is correct for non-power-of-2 NUM_INPUTS.
  - The pointer is frozen while RR_MODE=0 (stays 0).
- Simultaneous events: a tail-flit input transfer and an output transfer in the same cycle is normal. In the next cycle the arbiter is unlocked and arbitrates with the new pointer; there is no dead cycle between packets.
- Reset mid-packet: the lock is dropped and the output flit is discarded. Upstream FIFOs must be reset together with this block.
- Assertion expectations:
  - o_ready is always one-hot or zero.
  - o_data, o_last and o_src_idx are stable while o_valid && !i_ready.

Test Plan:
- Single-flit RR fairness: NUM_INPUTS=5, all five inputs hold single-flit packets, i_ready=1 -> o_src_idx sequence 0,1,2,3,4,0,... with o_valid=1 every cycle from cycle 1.
- Packet locking: input 1 sends a 4-flit packet (i_last on flit 4) while input 2 is continuously valid -> four flits from src 1 back-to-back, o_ready[2]=0 throughout, o_locked=1 for 3 cycles; src 2 follows the src 1 tail with no idle cycle.
- Mid-packet bubble: locked input 3 drops i_valid for 2 cycles while input 0 is valid -> o_valid=0 for 2 cycles, no flit from src 0 until the src 3 tail transfers.
- Backpressure: i_ready=0 for 5 cycles with o_valid=1 -> o_data/o_src_idx held, all o_ready=0. i_ready returns -> every flit delivered in order, none lost or duplicated.
- Fixed priority: RR_MODE=0, inputs 0 and 3 both continuously valid with single flits -> only src 0 is output; src 3 starves by design.
- Async reset mid-packet: assert i_arst_n=0 during flit 2 of a 3-flit packet -> o_valid, o_locked and o_ready drop immediately. After release, inputs 4 and 0 are valid -> src 0 is granted first (pointer=0).
